spi_device_byte: RTL and testbench



---
 rtl/spi_device_byte.sv | 202 ++++++++++++++++++++
 tb/tb_spi_device_byte.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_device_byte.sv
// SPI mode-0 target: oversampled SCK/CS/MOSI, byte-wide RX/TX valid/ready interfaces, sticky error flags.
// Optional macro SPI_DEVICE_MISO_OE_EN adds spi_miso_oe_o for shared-MISO tri-state control.
module spi_device_byte #(
  parameter int unsigned SyncStages = 2,
  parameter bit          MsbFirst   = 1'b1,
  parameter logic [7:0]  IdleByte   = 8'hFF
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       spi_sck_i,
  input  logic       spi_csn_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
`ifdef SPI_DEVICE_MISO_OE_EN
  output logic       spi_miso_oe_o,
`endif
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       rx_overrun_o,
  output logic       tx_underrun_o,
  input  logic       flags_clr_i,
  output logic       busy_o
);

  typedef enum logic {StIdle, StActive} state_e;

  logic [SyncStages-1:0] sck_sync_q, sck_sync_d;
  logic [SyncStages-1:0] csn_sync_q, csn_sync_d;
  logic [SyncStages-1:0] mosi_sync_q, mosi_sync_d;
  logic                  sck_hist_q, sck_hist_d;
  logic                  csn_hist_q, csn_hist_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       reload_q, reload_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic       underrun_q, underrun_d;

  logic sck_s, csn_s, mosi_s;
  logic sck_rise, sck_fall, csn_rise, csn_fall;
  logic load_tx, byte_done, overrun_set, underrun_set;

  assign sck_s  = sck_sync_q[SyncStages-1];
  assign csn_s  = csn_sync_q[SyncStages-1];
  assign mosi_s = mosi_sync_q[SyncStages-1];

  assign sck_rise = sck_s & ~sck_hist_q;
  assign sck_fall = ~sck_s & sck_hist_q;
  assign csn_rise = csn_s & ~csn_hist_q;
  assign csn_fall = ~csn_s & csn_hist_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
    sck_sync_d   = {sck_sync_q[SyncStages-2:0], spi_sck_i};
    csn_sync_d   = {csn_sync_q[SyncStages-2:0], spi_csn_i};
    mosi_sync_d  = {mosi_sync_q[SyncStages-2:0], spi_mosi_i};
    sck_hist_d   = sck_s;
    csn_hist_d   = csn_s;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    reload_d     = reload_q;
    rx_shift_d   = rx_shift_q;
    tx_shift_d   = tx_shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    load_tx      = 1'b0;
    byte_done    = 1'b0;
    overrun_set  = 1'b0;
    underrun_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (csn_fall) begin
          state_d   = StActive;
          bit_cnt_d = 3'd0;
          reload_d  = 1'b0;
          load_tx   = 1'b1;
        end
      end
      StActive: begin
        if (csn_rise) begin
          // Aborting mid-byte drops partial RX bits and unsent TX bits.
          state_d    = StIdle;
          bit_cnt_d  = 3'd0;
          reload_d   = 1'b0;
          rx_shift_d = 8'h00;
          tx_shift_d = 8'h00;
        end else begin
          if (sck_rise) begin
            rx_shift_d = MsbFirst ? {rx_shift_q[6:0], mosi_s} : {mosi_s, rx_shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              byte_done = 1'b1;
              reload_d  = 1'b1;
            end
          end
          if (sck_fall) begin
            if (reload_q) begin
              load_tx  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = MsbFirst ? {tx_shift_q[6:0], 1'b0} : {1'b0, tx_shift_q[7:1]};
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_tx) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d   = IdleByte;
        underrun_set = 1'b1;
      end
    end
    // Ready is taken from the registered state, so a same-cycle load never frees the slot early.
    if (tx_valid_i && tx_ready_o) begin
      hold_d      = tx_data_i;
      hold_full_d = 1'b1;
    end

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
    if (byte_done) begin
      if (rx_valid_q && !rx_ready_i) begin
        overrun_set = 1'b1;
      end else begin
        rx_data_d  = rx_shift_d;
        rx_valid_d = 1'b1;
      end
    end

    overrun_d  = (overrun_q & ~flags_clr_i) | overrun_set;
    underrun_d = (underrun_q & ~flags_clr_i) | underrun_set;
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      // NOTE: CS synchronizer resets low so a CS already low at reset release never looks like a fall.
      sck_sync_q  <= '0;
      csn_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_hist_q  <= 1'b0;
      csn_hist_q  <= 1'b0;
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      reload_q    <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
      sck_sync_q  <= sck_sync_d;
      csn_sync_q  <= csn_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_hist_q  <= sck_hist_d;
      csn_hist_q  <= csn_hist_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      reload_q    <= reload_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  assign busy_o        = (state_q == StActive);
  assign spi_miso_o    = busy_o & (MsbFirst ? tx_shift_q[7] : tx_shift_q[0]);
  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign tx_ready_o    = ~hold_full_q;
  assign rx_overrun_o  = overrun_q;
  assign tx_underrun_o = underrun_q;
`ifdef SPI_DEVICE_MISO_OE_EN
  assign spi_miso_oe_o = busy_o;
`endif

endmodule

// File: tb/tb_spi_device_byte.sv
// Directed bench for spi_device_byte: host-side SPI mode-0 driver at f_clk/8 with hand-computed expectations.
module tb_spi_device_byte;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       spi_sck, spi_csn, spi_mosi;
  logic       spi_miso_o;
  logic [7:0] rx_data_o;
  logic       rx_valid_o, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready_o;
  logic       rx_overrun_o, tx_underrun_o, flags_clr, busy_o;
`ifdef SPI_DEVICE_MISO_OE_EN
  logic       spi_miso_oe_o;
`endif

  int checks   = 0;
  int failures = 0;
  int lat;
  logic [7:0] mi, m0, m1, m2;
  logic [7:0] rx_log[$];

  always #5 clk = ~clk;

  spi_device_byte dut (
    .clk_sys_i    (clk),
    .rst_sys_ni   (rst_n),
    .spi_sck_i    (spi_sck),
    .spi_csn_i    (spi_csn),
    .spi_mosi_i   (spi_mosi),
    .spi_miso_o   (spi_miso_o),
`ifdef SPI_DEVICE_MISO_OE_EN
    .spi_miso_oe_o(spi_miso_oe_o),
`endif
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready_o),
    .rx_overrun_o (rx_overrun_o),
    .tx_underrun_o(tx_underrun_o),
    .flags_clr_i  (flags_clr),
    .busy_o       (busy_o)
  );

  // Consumer-side log of every RX handshake.
  always @(negedge clk) begin
    if (rst_n && rx_valid_o && rx_ready) rx_log.push_back(rx_data_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic oe_check(input logic exp);
`ifdef SPI_DEVICE_MISO_OE_EN
    check("miso_oe", {31'd0, spi_miso_oe_o}, {31'd0, exp});
`endif
  endtask

  // Inputs change and outputs are read 2 ns after a rising edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] d);
    bit done = 1'b0;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (tx_ready_o) begin
        @(posedge clk);
        #2;
        done = 1'b1;
      end
    end
    tx_valid = 1'b0;
    if (!done) check("tx_push_timeout", 32'd0, 32'd1);
  endtask

  task automatic cs_low();
    spi_csn = 1'b0;
    cyc(6);
  endtask

  task automatic cs_high();
    cyc(4);
    spi_csn = 1'b1;
    cyc(6);
  endtask

  task automatic pulse_clr();
    flags_clr = 1'b1;
    cyc(1);
    flags_clr = 1'b0;
    cyc(1);
  endtask

  task automatic rx_pop();
    rx_ready = 1'b1;
    cyc(1);
    rx_ready = 1'b0;
    cyc(1);
  endtask

  // MSB-first host transfer; lat = edges from the last SCK rise until rx_valid_o is seen.
  task automatic xfer(input logic [7:0] mo, input int nbits, output logic [7:0] got);
    got = 8'h00;
    lat = 0;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = mo[7-b];
      cyc(4);
      got     = {got[6:0], spi_miso_o};
      spi_sck = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        cyc(1);
        if (lat == 0 && rx_valid_o) lat = k;
      end
      spi_sck = 1'b0;
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
    rx_ready = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; flags_clr = 1'b0;
    cyc(3);
    check("rst_miso",     {31'd0, spi_miso_o},    32'd0);
    check("rst_rx_data",  {24'd0, rx_data_o},     32'd0);
    check("rst_rx_valid", {31'd0, rx_valid_o},    32'd0);
    check("rst_tx_ready", {31'd0, tx_ready_o},    32'd1);
    check("rst_overrun",  {31'd0, rx_overrun_o},  32'd0);
    check("rst_underrun", {31'd0, tx_underrun_o}, 32'd0);
    check("rst_busy",     {31'd0, busy_o},        32'd0);
    oe_check(1'b0);
    rst_n = 1'b1;
    cyc(4);

    // Single byte: preloaded A5 out, 3C in.
    push(8'hA5);
    check("t1_tx_full", {31'd0, tx_ready_o}, 32'd0);
    cs_low();
    check("t1_busy",       {31'd0, busy_o},     32'd1);
    check("t1_tx_ready",   {31'd0, tx_ready_o}, 32'd1);
    oe_check(1'b1);
    xfer(8'h3C, 8, mi);
    check("t1_miso",     {24'd0, mi},         32'hA5);
    check("t1_rx_lat",   lat,                 32'd3);
    check("t1_rx_data",  {24'd0, rx_data_o},  32'h3C);
    check("t1_rx_valid", {31'd0, rx_valid_o}, 32'd1);
    cs_high();
    check("t1_busy_off",  {31'd0, busy_o},        32'd0);
    oe_check(1'b0);
    // Final SCK fall reloads from an empty holding register.
    check("t1_underrun",  {31'd0, tx_underrun_o}, 32'd1);
    rx_pop();
    check("t1_rx_popped", {31'd0, rx_valid_o},    32'd0);
    pulse_clr();
    check("t1_flag_clr",  {31'd0, tx_underrun_o}, 32'd0);

    // Three-byte frame with continuous consumer.
    rx_log.delete();
    rx_ready = 1'b1;
    push(8'h10);
    cs_low();
    push(8'h20);
    xfer(8'h01, 8, m0);
    xfer(8'h02, 8, m1);
    xfer(8'h03, 8, m2);
    cs_high();
    rx_ready = 1'b0;
    check("t2_miso0",    {24'd0, m0},            32'h10);
    check("t2_miso1",    {24'd0, m1},            32'h20);
    check("t2_miso2",    {24'd0, m2},            32'hFF);
    check("t2_underrun", {31'd0, tx_underrun_o}, 32'd1);
    check("t2_rx_count", rx_log.size(),          32'd3);
    if (rx_log.size() == 3) begin
      check("t2_rx0", {24'd0, rx_log[0]}, 32'h01);
      check("t2_rx1", {24'd0, rx_log[1]}, 32'h02);
      check("t2_rx2", {24'd0, rx_log[2]}, 32'h03);
    end
    check("t2_rx_valid", {31'd0, rx_valid_o}, 32'd0);
    check("t2_overrun",  {31'd0, rx_overrun_o}, 32'd0);

    // Overrun: two bytes with nobody consuming.
    pulse_clr();
    cs_low();
    xfer(8'h11, 8, mi);
    xfer(8'h22, 8, mi);
    cs_high();
    check("t3_rx_data",  {24'd0, rx_data_o},    32'h11);
    check("t3_rx_valid", {31'd0, rx_valid_o},   32'd1);
    check("t3_overrun",  {31'd0, rx_overrun_o}, 32'd1);
    pulse_clr();
    check("t3_clr",      {31'd0, rx_overrun_o}, 32'd0);
    rx_pop();

    // CS abort after five SCK rises.
    cs_low();
    xfer(8'hC0, 5, mi);
    cyc(2);
    spi_csn = 1'b1;
    cyc(2);
    check("t4_busy_hold", {31'd0, busy_o}, 32'd1);
    cyc(1);
    check("t4_busy_drop", {31'd0, busy_o}, 32'd0);
    cyc(4);
    check("t4_no_valid",  {31'd0, rx_valid_o}, 32'd0);
    cs_low();
    xfer(8'h7E, 8, mi);
    cs_high();
    check("t4_miso_idle", {24'd0, mi},         32'hFF);
    check("t4_rx_data",   {24'd0, rx_data_o},  32'h7E);
    check("t4_rx_valid",  {31'd0, rx_valid_o}, 32'd1);

    // Reset mid-byte with state everywhere non-default.
    push(8'h96);
    cs_low();
    push(8'h69);
    xfer(8'hAA, 4, mi);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rx_data",  {24'd0, rx_data_o},     32'd0);
    check("t5_rx_valid", {31'd0, rx_valid_o},    32'd0);
    check("t5_tx_ready", {31'd0, tx_ready_o},    32'd1);
    check("t5_busy",     {31'd0, busy_o},        32'd0);
    check("t5_miso",     {31'd0, spi_miso_o},    32'd0);
    check("t5_underrun", {31'd0, tx_underrun_o}, 32'd0);
    oe_check(1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    xfer(8'hAA, 4, mi);
    check("t5_no_resume", {31'd0, busy_o},     32'd0);
    cs_high();
    check("t5_no_rx",     {31'd0, rx_valid_o}, 32'd0);
    push(8'h5A);
    cs_low();
    check("t5_busy_new",  {31'd0, busy_o},     32'd1);
    xfer(8'hC3, 8, mi);
    cs_high();
    check("t5_miso_new",  {24'd0, mi},         32'h5A);
    check("t5_rx_new",    {24'd0, rx_data_o},  32'hC3);
    check("t5_valid_new", {31'd0, rx_valid_o}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
